// File: rtl/dphy_pkg.sv
// Shared D-PHY definitions used by the HS receive controller and its byte aligner.
package dphy_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / BYTE_W;

  // Leader byte that opens every HS burst; the TX HS controller sends this same value.
  localparam logic [BYTE_W-1:0] HS_SYNC_BYTE = 8'h1D;

  typedef enum logic [2:0] {
    RX_OFF,
    RX_SETTLE,
    RX_SYNC_SRCH,
    RX_DATA,
    RX_FLUSH,
    RX_ERR
  } rx_state_t;

  // Byte mask with the lowest n lanes set (n = 1..3 for a partial word).
  function automatic logic [LANES-1:0] low_mask(input logic [1:0] n);
    low_mask = LANES'((1 << n) - 1);
  endfunction

endpackage

// File: rtl/dphy_byte_aligner.sv
// Byte aligner: 16-bit window {current, previous}, 8-offset sync search with
// single-bit-error tolerance, and aligned byte output at the latched offset.
module dphy_byte_aligner
  import dphy_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              lock,
  input  logic [BYTE_W-1:0] data_in,
  output logic              hit,
  output logic              hit_err1,
  output logic [BYTE_W-1:0] aligned
);

  logic [BYTE_W-1:0]   prev_byte;
  logic [2*BYTE_W-1:0] win_nxt;
  logic [2:0]          offset;
  logic [2:0]          k_exact;
  logic [2:0]          k_one;
  logic                exact;
  logic                one;
  logic [BYTE_W-1:0]   cand;

  // The window as it looks once the incoming byte is accepted; search and
  // alignment both act on it so lock and data need no extra cycle.
  assign win_nxt = {data_in, prev_byte};

  // Previous-byte half of the window and the offset latched at lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_byte <= '0;
      offset    <= '0;
    end else begin
      if (shift) prev_byte <= data_in;
      if (lock)  offset    <= hit_err1 ? k_one : k_exact;
    end
  end

  // Scan offsets high to low so the lowest matching offset is the one kept.
  always_comb begin
    exact   = 1'b0;
    one     = 1'b0;
    k_exact = '0;
    k_one   = '0;
    cand    = '0;
    for (int k = BYTE_W - 1; k >= 0; k--) begin
      cand = win_nxt[k +: BYTE_W];
      if (cand == HS_SYNC_BYTE) begin
        exact   = 1'b1;
        k_exact = 3'(k);
      end
      if ($countones(cand ^ HS_SYNC_BYTE) == 1) begin
        one   = 1'b1;
        k_one = 3'(k);
      end
    end
  end

  assign hit      = exact || one;
  assign hit_err1 = !exact && one;
  assign aligned  = win_nxt[offset +: BYTE_W];

endmodule

// File: rtl/data_hs_rx_ctl.sv
// HS receive controller: settle, SoT sync search, byte holdoff and 32-bit packing.
//
//   state        | meaning
//   RX_OFF       | lane idle, waiting for hs_rx_en
//   RX_SETTLE    | HS-settle wait, deserializer output ignored
//   RX_SYNC_SRCH | looking for the sync byte at any of 8 bit offsets
//   RX_DATA      | locked; aligned bytes go through holdoff into the packer
//   RX_FLUSH     | burst ended; emit any partial word, drop the trail byte
//   RX_ERR       | sync never found; wait for hs_rx_en to drop
module data_hs_rx_ctl
  import dphy_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hs_rx_en,
  input  logic              deser_valid,
  input  logic [BYTE_W-1:0] deser_data,
  output logic              RxActiveHS,
  output logic              RxSyncHS,
  output logic              RxValidHS,
  output logic [WORD_W-1:0] RxDataHS,
  output logic [LANES-1:0]  RxByteMask,
  output logic              ErrSotHS,
  output logic              ErrSotSyncHS
);

  rx_state_t                      state;
  logic [7:0]                     settle_cnt;
  logic [7:0]                     srch_cnt;
  logic [BYTE_W-1:0]              hold_byte;
  logic                           hold_vld;
  logic [(LANES-1)*BYTE_W-1:0]    pack_word;
  logic [1:0]                     pack_cnt;
  logic                           in_srch;
  logic                           armed;
  logic                           shift;
  logic                           lock_now;
  logic                           hit;
  logic                           hit_err1;
  logic [BYTE_W-1:0]              aligned;

  // Search is armed from the second byte of the search phase onward.
  assign in_srch  = (state == RX_SYNC_SRCH);
  assign armed    = (srch_cnt != 8'(SYNC_TIMEOUT - 1));
  assign shift    = deser_valid && hs_rx_en && (in_srch || state == RX_DATA);
  assign lock_now = in_srch && hs_rx_en && deser_valid && armed && hit;

  dphy_byte_aligner u_aligner (
    .clk      (clk),
    .rst      (rst),
    .shift    (shift),
    .lock     (lock_now),
    .data_in  (deser_data),
    .hit      (hit),
    .hit_err1 (hit_err1),
    .aligned  (aligned)
  );

  // Receive FSM with holdoff, packer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RX_OFF;
      settle_cnt   <= '0;
      srch_cnt     <= '0;
      hold_byte    <= '0;
      hold_vld     <= 1'b0;
      pack_word    <= '0;
      pack_cnt     <= '0;
      RxActiveHS   <= 1'b0;
      RxSyncHS     <= 1'b0;
      RxValidHS    <= 1'b0;
      RxDataHS     <= '0;
      RxByteMask   <= '0;
      ErrSotHS     <= 1'b0;
      ErrSotSyncHS <= 1'b0;
    end else begin
      RxSyncHS     <= 1'b0;
      RxValidHS    <= 1'b0;
      ErrSotHS     <= 1'b0;
      ErrSotSyncHS <= 1'b0;
      case (state)
        RX_OFF: begin
          if (hs_rx_en) begin
            state      <= RX_SETTLE;
            settle_cnt <= 8'(SETTLE_CYCLES - 1);
          end
        end
        RX_SETTLE: begin
          if (!hs_rx_en) begin
            state <= RX_OFF;
          end else if (settle_cnt == '0) begin
            state    <= RX_SYNC_SRCH;
            srch_cnt <= 8'(SYNC_TIMEOUT - 1);
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        RX_SYNC_SRCH: begin
          if (!hs_rx_en) begin
            state <= RX_OFF;
          end else if (deser_valid) begin
            if (lock_now) begin
              state      <= RX_DATA;
              RxSyncHS   <= 1'b1;
              RxActiveHS <= 1'b1;
              ErrSotHS   <= hit_err1;
              hold_vld   <= 1'b0;
              pack_word  <= '0;
              pack_cnt   <= '0;
            end else if (srch_cnt == '0) begin
              state        <= RX_ERR;
              ErrSotSyncHS <= 1'b1;
            end else begin
              srch_cnt <= srch_cnt - 8'd1;
            end
          end
        end
        RX_DATA: begin
          if (!hs_rx_en) begin
            state <= RX_FLUSH;
          end else if (deser_valid) begin
            // The held byte is committed only now that a successor exists.
            if (hold_vld) begin
              if (pack_cnt == 2'd3) begin
                RxValidHS  <= 1'b1;
                RxDataHS   <= {hold_byte, pack_word};
                RxByteMask <= 4'hF;
                pack_word  <= '0;
                pack_cnt   <= '0;
              end else begin
                pack_word[{pack_cnt, 3'b000} +: BYTE_W] <= hold_byte;
                pack_cnt <= pack_cnt + 2'd1;
              end
            end
            hold_byte <= aligned;
            hold_vld  <= 1'b1;
          end
        end
        RX_FLUSH: begin
          if (pack_cnt != '0) begin
            RxValidHS  <= 1'b1;
            RxDataHS   <= {{BYTE_W{1'b0}}, pack_word};
            RxByteMask <= low_mask(pack_cnt);
          end
          RxActiveHS <= 1'b0;
          hold_vld   <= 1'b0;
          pack_word  <= '0;
          pack_cnt   <= '0;
          state      <= RX_OFF;
        end
        RX_ERR: begin
          if (!hs_rx_en) state <= RX_OFF;
        end
        default: state <= RX_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_data_hs_rx_ctl.sv
// Bench for data_hs_rx_ctl: directed bursts plus randomized bursts checked
// against a bit-stream reference model.
module tb_data_hs_rx_ctl;

  localparam int SETTLE = 4;
  localparam int TMO    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs_rx_en;
  logic        deser_valid;
  logic [7:0]  deser_data;
  logic        RxActiveHS;
  logic        RxSyncHS;
  logic        RxValidHS;
  logic [31:0] RxDataHS;
  logic [3:0]  RxByteMask;
  logic        ErrSotHS;
  logic        ErrSotSyncHS;

  always #5 clk = ~clk;

  data_hs_rx_ctl #(
    .SETTLE_CYCLES (SETTLE),
    .SYNC_TIMEOUT  (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hs_rx_en     (hs_rx_en),
    .deser_valid  (deser_valid),
    .deser_data   (deser_data),
    .RxActiveHS   (RxActiveHS),
    .RxSyncHS     (RxSyncHS),
    .RxValidHS    (RxValidHS),
    .RxDataHS     (RxDataHS),
    .RxByteMask   (RxByteMask),
    .ErrSotHS     (ErrSotHS),
    .ErrSotSyncHS (ErrSotSyncHS)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output monitor
  int          n_sync, n_err1, n_tmo;
  logic        sync_err, sync_act;
  logic [31:0] obs_d[$];
  logic [3:0]  obs_m[$];

  always @(negedge clk) begin
    if (RxValidHS) begin
      obs_d.push_back(RxDataHS);
      obs_m.push_back(RxByteMask);
    end
    if (RxSyncHS) begin
      n_sync++;
      sync_err = ErrSotHS;
      sync_act = RxActiveHS;
    end
    if (ErrSotHS)     n_err1++;
    if (ErrSotSyncHS) n_tmo++;
  end

  task automatic clear_mon();
    n_sync = 0; n_err1 = 0; n_tmo = 0; sync_err = 1'b0; sync_act = 1'b0;
    obs_d.delete(); obs_m.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus: carried bytes cq are laid after junk bits into deserializer bytes dq
  logic [7:0]  cq[$];
  logic [7:0]  dq[$];
  bit          mb[$];
  logic [31:0] exp_d[$];
  logic [3:0]  exp_m[$];
  bit          exp_lock, exp_err1, exp_tmo;
  logic [31:0] last_d = '0;
  logic [3:0]  last_m = '0;

  task automatic build_stream(input int junk);
    bit sb[$];
    int total;
    logic [7:0] b;
    for (int i = 0; i < junk; i++) sb.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < cq.size(); i++)
      for (int j = 0; j < 8; j++) sb.push_back(cq[i][j]);
    total = ((junk + 8 * cq.size()) / 8 + 1) * 8;
    while (sb.size() < total) sb.push_back(1'($urandom_range(0, 1)));
    dq.delete();
    for (int i = 0; i < total / 8; i++) begin
      for (int j = 0; j < 8; j++) b[j] = sb[8 * i + j];
      dq.push_back(b);
    end
  endtask

  function automatic logic [7:0] take(input int p);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = mb[p + j];
    return r;
  endfunction

  function automatic int sync_dist(input int p);
    return $countones(take(p) ^ 8'h1D);
  endfunction

  // Reference: scan the received bit stream for the sync byte, then every later
  // byte arrival yields the next 8 bits after it; the last one is the trail.
  task automatic model_run();
    int lock_i, lock_k, nb;
    logic [7:0]  al[$];
    logic [31:0] w;
    exp_d.delete(); exp_m.delete();
    exp_lock = 0; exp_err1 = 0; exp_tmo = 0;
    mb.delete();
    for (int i = 0; i < dq.size(); i++)
      for (int b = 0; b < 8; b++) mb.push_back(dq[i][b]);
    lock_i = -1; lock_k = 0;
    for (int i = 0; i < dq.size(); i++) begin
      int ke, k1;
      ke = -1; k1 = -1;
      if (i >= 1) begin
        for (int k = 0; k < 8; k++) begin
          if (sync_dist(8 * (i - 1) + k) == 0 && ke < 0) ke = k;
          if (sync_dist(8 * (i - 1) + k) == 1 && k1 < 0) k1 = k;
        end
      end
      if (ke >= 0) begin lock_i = i; lock_k = ke; break; end
      if (k1 >= 0) begin lock_i = i; lock_k = k1; exp_err1 = 1; break; end
      if (i == TMO - 1) begin exp_tmo = 1; break; end
    end
    exp_lock = (lock_i >= 0);
    if (exp_lock)
      for (int j = lock_i + 1; j < dq.size(); j++) al.push_back(take(8 * (j - 1) + lock_k));
    if (al.size() > 0) void'(al.pop_back());
    w = '0; nb = 0;
    for (int i = 0; i < al.size(); i++) begin
      w[8 * nb +: 8] = al[i];
      nb++;
      if (nb == 4) begin
        exp_d.push_back(w); exp_m.push_back(4'hF);
        w = '0; nb = 0;
      end
    end
    if (nb > 0) begin
      exp_d.push_back(w);
      exp_m.push_back(4'((1 << nb) - 1));
    end
  endtask

  task automatic compare(input string name);
    check_val({name, ":sync"}, 64'(n_sync), 64'(exp_lock));
    if (exp_lock && n_sync == 1) begin
      check_val({name, ":sync_err"}, 64'(sync_err), 64'(exp_err1));
      check_val({name, ":active_at_sync"}, 64'(sync_act), 64'd1);
    end
    check_val({name, ":errsot"}, 64'(n_err1), 64'(exp_err1));
    check_val({name, ":errsync"}, 64'(n_tmo), 64'(exp_tmo));
    check_val({name, ":nwords"}, 64'(obs_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++)
      check_val($sformatf("%s:word%0d", name, i), {28'h0, obs_m[i], obs_d[i]}, {28'h0, exp_m[i], exp_d[i]});
    if (exp_d.size() > 0) begin
      last_d = exp_d[exp_d.size() - 1];
      last_m = exp_m[exp_m.size() - 1];
    end
    check_val({name, ":hold"}, {28'h0, RxByteMask, RxDataHS}, {28'h0, last_m, last_d});
    check_val({name, ":active_end"}, 64'(RxActiveHS), 64'd0);
  endtask

  task automatic feed_bytes();
    for (int i = 0; i < dq.size(); i++) begin
      deser_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      deser_valid = 1'b1;
      deser_data  = dq[i];
      step();
    end
    deser_valid = 1'b0;
  endtask

  task automatic run_pkt(input string name, input bit drop_with_valid);
    clear_mon();
    hs_rx_en = 1'b1;
    repeat (SETTLE + 2) step();
    feed_bytes();
    hs_rx_en = 1'b0;
    if (drop_with_valid) begin
      deser_valid = 1'b1;
      deser_data  = 8'($urandom);
    end
    step();
    deser_valid = 1'b0;
    repeat (6) step();
    model_run();
    compare(name);
  endtask

  function automatic logic [63:0] obs_word(input int i);
    if (obs_d.size() > i) return {28'h0, obs_m[i], obs_d[i]};
    return 64'hx;
  endfunction

  initial begin
    rst = 1'b1; hs_rx_en = 1'b0; deser_valid = 1'b0; deser_data = '0;
    clear_mon();
    repeat (3) step();
    check_val("rst_flags", {58'h0, RxActiveHS, RxSyncHS, RxValidHS, ErrSotHS, ErrSotSyncHS, 1'b0}, 64'h0);
    check_val("rst_data", {28'h0, RxByteMask, RxDataHS}, 64'h0);
    rst = 1'b0;
    repeat (2) step();

    // Aligned stream, FF is the trail byte
    cq = '{8'h1D, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hFF};
    build_stream(0);
    run_pkt("aligned", 1'b0);
    check_val("aligned_w0", obs_word(0), {28'h0, 4'hF, 32'h44332211});
    check_val("aligned_w1", obs_word(1), {28'h0, 4'h1, 32'h00000055});

    // Stream shifted by 3 bits
    cq = '{8'h1D, 8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h00};
    build_stream(3);
    run_pkt("shift3", 1'b0);
    check_val("shift3_w0", obs_word(0), {28'h0, 4'hF, 32'h3CC35AA5});

    // One-bit sync error
    cq = '{8'h1C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    build_stream(0);
    run_pkt("sync_1err", 1'b1);
    check_val("sync_1err_flag", 64'(sync_err), 64'd1);
    check_val("sync_1err_w0", obs_word(0), {28'h0, 4'hF, 32'h44332211});

    // Sync timeout; a later valid sync must be ignored until hs_rx_en drops
    dq.delete();
    repeat (TMO) dq.push_back(8'h00);
    dq.push_back(8'h1D); dq.push_back(8'h11); dq.push_back(8'h22); dq.push_back(8'h33);
    run_pkt("timeout", 1'b0);
    check_val("timeout_once", 64'(n_tmo), 64'd1);

    // hs_rx_en drops at cycle 2 of settle
    clear_mon();
    hs_rx_en = 1'b1;
    step(); step();
    hs_rx_en = 1'b0;
    dq = '{8'h1D, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    feed_bytes();
    repeat (6) step();
    check_val("settle_drop_pulses", 64'(n_sync + n_err1 + n_tmo), 64'd0);
    check_val("settle_drop_words", 64'(obs_d.size()), 64'd0);
    check_val("settle_drop_active", 64'(RxActiveHS), 64'd0);

    // Reset in RX_DATA with two bytes packed
    clear_mon();
    dq = '{8'h1D, 8'h11, 8'h22, 8'h33, 8'h44};
    hs_rx_en = 1'b1;
    repeat (SETTLE + 2) step();
    feed_bytes();
    step();
    check_val("rstmid_active_before", 64'(RxActiveHS), 64'd1);
    rst = 1'b1;
    step();
    check_val("rstmid_flags", {58'h0, RxActiveHS, RxSyncHS, RxValidHS, ErrSotHS, ErrSotSyncHS, 1'b0}, 64'h0);
    check_val("rstmid_data", {28'h0, RxByteMask, RxDataHS}, 64'h0);
    rst = 1'b0;
    hs_rx_en = 1'b0;
    repeat (6) step();
    check_val("rstmid_no_flush", 64'(obs_d.size()), 64'd0);
    last_d = '0; last_m = '0;

    // Randomized bursts
    for (int n = 0; n < 30; n++) begin
      logic [7:0] s;
      int len;
      s = 8'h1D;
      if ($urandom_range(0, 1) == 1) s[$urandom_range(0, 7)] ^= 1'b1;
      cq.delete();
      cq.push_back(s);
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) cq.push_back(8'($urandom));
      build_stream($urandom_range(0, 20));
      run_pkt($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
